preg_freelist: RTL and testbench

- Physical-register free list and committed (architectural) map table; the release side of the rename allocator.
- Consumes retire entries from the ROB commit port, updates the committed areg->preg map, and returns the displaced preg to a circular free FIFO.
- Supplies free pregs to rename on demand.
- On squash, rebuilds the free FIFO from the committed map with a sequential scan.

---
 rtl/preg_freelist_if.sv | 19 +
 rtl/preg_freelist.sv | 176 +++++++++++++++++
 tb/tb_preg_freelist.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/preg_freelist_if.sv
// Shared retire-entry type and the squash handshake seen by the free list.
// The ROB entry fields are sized for the largest supported configuration; narrower builds use the low bits.
package preg_freelist_pkg;
  localparam int ROB_PREG_BITS = 6;
  localparam int ROB_AREG_BITS = 5;

  typedef struct packed {
    logic                     needprf2arf;
    logic [ROB_AREG_BITS-1:0] ard;
    logic [ROB_PREG_BITS-1:0] prd;
  } rob_entry_t;
endpackage

interface squash_if;
  logic valid;

  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/preg_freelist.sv
// Physical-register free list with committed map table; recycles displaced pregs
// at retire and rebuilds the free FIFO from the committed map after a squash.
module preg_freelist_chk #(
  parameter int PRFSIZE      = 64,
  parameter int PREG_ID_BITS = $clog2(PRFSIZE)
) (
  input logic                  clk,
  input logic                  rstn,
  input logic                  retire_s,
  input logic                  rebuilding_s,
  input logic                  push_s,
  input logic                  squash_s,
  input logic [PREG_ID_BITS:0] count_s
);
  // Protocol and capacity checks, sampled at each active edge out of reset
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(retire_s && rebuilding_s))
        else $error("retire while rebuilding");
      assert (!(push_s && !squash_s && (count_s == (PREG_ID_BITS+1)'(PRFSIZE))))
        else $error("push into a full free list");
    end
  end
endmodule

module preg_freelist #(
  parameter int PRFSIZE      = 64,
  parameter int ARFSIZE      = 32,
  parameter int PREG_ID_BITS = $clog2(PRFSIZE),
  parameter int AREG_ID_BITS = $clog2(ARFSIZE)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          alloc_i,
  output logic                          alloc_ready_o,
  output logic [PREG_ID_BITS-1:0]       alloc_preg_o,
  input  preg_freelist_pkg::rob_entry_t retire_entry_i,
  input  logic                          retire_entry_i_valid,
  squash_if.slave                       squash_io,
  output logic [PREG_ID_BITS:0]         free_count_o,
  output logic                          rebuilding_o
);
  typedef enum logic {REBUILD = 1'b0, READY = 1'b1} state_t;
  typedef logic [PREG_ID_BITS-1:0] preg_t;
  typedef logic [PREG_ID_BITS:0]   cnt_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  preg_t                   fifo_r [PRFSIZE];
  preg_t                   arat_r [ARFSIZE];
  logic [ARFSIZE-1:0]      arat_valid_r;
  logic [PRFSIZE-1:0]      inuse_r;
  preg_t                   head_r;
  preg_t                   tail_r;
  cnt_t                    count_r;
  cnt_t                    scan_idx_r;

  logic [AREG_ID_BITS-1:0] ard_s;
  preg_t                   prd_s;
  preg_t                   old_s;
  preg_t                   push_val_s;
  logic                    retire_s;
  logic                    displace_s;
  logic                    scan_free_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    squash_s;
  logic                    scan_last_s;

  // Retire decode plus push/pop arbitration; a retire never overlaps the scan
  always_comb begin
    ard_s       = retire_entry_i.ard[AREG_ID_BITS-1:0];
    prd_s       = retire_entry_i.prd[PREG_ID_BITS-1:0];
    old_s       = arat_r[ard_s];
    retire_s    = retire_entry_i_valid && retire_entry_i.needprf2arf;
    displace_s  = retire_s && arat_valid_r[ard_s] && (old_s != prd_s);
    scan_free_s = (state_r == REBUILD) && !inuse_r[scan_idx_r[PREG_ID_BITS-1:0]];
    push_s      = scan_free_s || displace_s;
    if (scan_free_s) begin
      push_val_s = scan_idx_r[PREG_ID_BITS-1:0];
    end else begin
      push_val_s = old_s;
    end
    pop_s       = alloc_i && alloc_ready_o;
    squash_s    = squash_io.valid;
    scan_last_s = (scan_idx_r == cnt_t'(PRFSIZE - 1));
  end

  // FSM next state: squash always restarts the scan
  always_comb begin
    state_nxt_s = state_r;
    if (squash_s) begin
      state_nxt_s = REBUILD;
    end else begin
      case (state_r)
        REBUILD: begin
          if (scan_last_s) begin
            state_nxt_s = READY;
          end else begin
            state_nxt_s = REBUILD;
          end
        end
        READY:   state_nxt_s = READY;
        default: state_nxt_s = REBUILD;
      endcase
    end
  end

  // State, FIFO pointers, occupancy and scan index
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= REBUILD;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      scan_idx_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (squash_s) begin
        head_r     <= '0;
        tail_r     <= '0;
        count_r    <= '0;
        scan_idx_r <= '0;
      end else begin
        if (push_s) tail_r <= tail_r + preg_t'(1);
        if (pop_s)  head_r <= head_r + preg_t'(1);
        count_r <= count_r + cnt_t'(push_s) - cnt_t'(pop_s);
        if (state_r == REBUILD) scan_idx_r <= scan_idx_r + cnt_t'(1);
      end
    end
  end

  // FIFO storage; a squash discards any same-cycle push
  always_ff @(posedge clk) begin
    if (rstn && !squash_s && push_s) begin
      fifo_r[tail_r] <= push_val_s;
    end
  end

  // Committed map contents; qualified by arat_valid_r so no reset needed
  always_ff @(posedge clk) begin
    if (rstn && retire_s) begin
      arat_r[ard_s] <= prd_s;
    end
  end

  // Committed map valid bits and committed-in-use vector
  always_ff @(posedge clk) begin
    if (!rstn) begin
      arat_valid_r <= '0;
      inuse_r      <= '0;
    end else if (retire_s) begin
      arat_valid_r[ard_s] <= 1'b1;
      inuse_r[prd_s]      <= 1'b1;
      if (displace_s) inuse_r[old_s] <= 1'b0;
    end
  end

  assign alloc_ready_o = (state_r == READY) && (count_r != '0);
  assign alloc_preg_o  = fifo_r[head_r];
  assign free_count_o  = count_r;
  assign rebuilding_o  = (state_r == REBUILD);

  preg_freelist_chk #(
    .PRFSIZE      (PRFSIZE),
    .PREG_ID_BITS (PREG_ID_BITS)
  ) u_chk (
    .clk          (clk),
    .rstn         (rstn),
    .retire_s     (retire_s),
    .rebuilding_s (rebuilding_o),
    .push_s       (push_s),
    .squash_s     (squash_s),
    .count_s      (count_r)
  );
endmodule

// File: tb/tb_preg_freelist.sv
// Directed bench for preg_freelist with PRFSIZE=8, ARFSIZE=4: vector table plus
// hand sequences for reset/squash rebuilds.
module tb_preg_freelist;
  localparam int PRF = 8;
  localparam int ARF = 4;
  localparam int PB  = 3;

  typedef struct {
    int alloc;
    int rv;
    int need;
    int ard;
    int prd;
    int sq;
    int e_ready;
    int e_preg;
    int e_count;
    int e_rebuild;
  } vec_t;

  logic                          clk;
  logic                          rstn;
  logic                          alloc_i;
  logic                          alloc_ready_o;
  logic [PB-1:0]                 alloc_preg_o;
  preg_freelist_pkg::rob_entry_t retire_entry_i;
  logic                          retire_entry_i_valid;
  logic [PB:0]                   free_count_o;
  logic                          rebuilding_o;

  squash_if sq_if ();

  int checks = 0;
  int errors = 0;
  vec_t tbl [29];

  preg_freelist #(.PRFSIZE(PRF), .ARFSIZE(ARF)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .alloc_i              (alloc_i),
    .alloc_ready_o        (alloc_ready_o),
    .alloc_preg_o         (alloc_preg_o),
    .retire_entry_i       (retire_entry_i),
    .retire_entry_i_valid (retire_entry_i_valid),
    .squash_io            (sq_if.slave),
    .free_count_o         (free_count_o),
    .rebuilding_o         (rebuilding_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int alloc, input int rv, input int need, input int ard,
                              input int prd, input int sq, input int e_ready, input int e_preg,
                              input int e_count, input int e_rebuild);
    vec_t v;
    v.alloc = alloc; v.rv = rv; v.need = need; v.ard = ard; v.prd = prd; v.sq = sq;
    v.e_ready = e_ready; v.e_preg = e_preg; v.e_count = e_count; v.e_rebuild = e_rebuild;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int alloc, input int rv, input int need, input int ard,
                       input int prd, input int sq);
    alloc_i                    = 1'(alloc);
    retire_entry_i_valid       = 1'(rv);
    retire_entry_i.needprf2arf = 1'(need);
    retire_entry_i.ard         = 5'(ard);
    retire_entry_i.prd         = 6'(prd);
    sq_if.valid                = 1'(sq);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_out(input string name, input int e_ready, input int e_preg,
                           input int e_count, input int e_rebuild);
    chk({name, ".ready"}, int'(alloc_ready_o), e_ready);
    chk({name, ".count"}, int'(free_count_o), e_count);
    chk({name, ".rebuild"}, int'(rebuilding_o), e_rebuild);
    if (e_ready != 0) chk({name, ".preg"}, int'(alloc_preg_o), e_preg);
  endtask

  // Reset (optionally with a colliding squash and retire), then an 8-cycle rebuild of all pregs
  task automatic reset_rebuild(input string tag, input int with_sq);
    drive(0, with_sq, with_sq, 0, 5, with_sq);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    idle();
    check_out({tag, "_rst"}, 0, 0, 0, 1);
    for (int k = 1; k <= PRF; k++) begin
      tick();
      if (k < PRF) check_out($sformatf("%s_scan%0d", tag, k), 0, 0, k, 1);
      else         check_out($sformatf("%s_done", tag), 1, 0, PRF, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int sq_counts [8];
    int sq_order  [6];
    sq_counts = '{1, 2, 2, 3, 4, 5, 5, 6};
    sq_order  = '{0, 1, 3, 4, 5, 7};

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 7, 0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0, 1, 1, 7, 0);
    tbl[2]  = mk(1, 1, 1, 1, 1, 0, 1, 2, 7, 0);
    tbl[3]  = mk(0, 1, 0, 2, 5, 0, 1, 2, 7, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1, 3, 6, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1, 4, 5, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 5, 4, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1, 6, 3, 0);
    tbl[8]  = mk(0, 1, 1, 2, 5, 0, 1, 6, 3, 0);
    tbl[9]  = mk(1, 1, 1, 2, 2, 0, 1, 7, 3, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 1, 0, 2, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 1, 5, 1, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 1, 3, 3, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 1, 3, 6, 0, 1, 3, 1, 0);
    tbl[15] = mk(0, 1, 1, 2, 4, 1, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 1, 2, 4, 0);
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    tbl[26] = mk(1, 0, 0, 0, 0, 0, 1, 5, 2, 0);
    tbl[27] = mk(1, 0, 0, 0, 0, 0, 1, 7, 1, 0);
    tbl[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rstn = 1'b0;
    idle();

    // Reset rebuild then drain: pregs come out in index order
    reset_rebuild("rst", 0);
    for (int i = 0; i < PRF; i++) begin
      chk($sformatf("drain_preg%0d", i), int'(alloc_preg_o), i);
      drive(1, 0, 0, 0, 0, 0);
      tick();
      chk($sformatf("drain_count%0d", i), int'(free_count_o), PRF - 1 - i);
    end
    idle();
    chk("drain_empty_ready", int'(alloc_ready_o), 0);

    // Recycle, push+pop, empty boundary and squash+retire via the vector table
    reset_rebuild("rst2", 0);
    foreach (tbl[i]) begin
      drive(tbl[i].alloc, tbl[i].rv, tbl[i].need, tbl[i].ard, tbl[i].prd, tbl[i].sq);
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_preg, tbl[i].e_count,
                tbl[i].e_rebuild);
    end
    idle();

    // Reset beats a same-cycle squash and retire: p5 must not stay committed
    reset_rebuild("rst_sq", 1);

    // Commit a0->p2, a3->p6, squash, restart mid-scan, then check free order
    drive(0, 1, 1, 0, 2, 0);
    tick();
    chk("commit_a0_count", int'(free_count_o), PRF);
    drive(0, 1, 1, 3, 6, 0);
    tick();
    chk("commit_a3_count", int'(free_count_o), PRF);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    idle();
    check_out("squash1", 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("squash1_scan%0d", k), 0, 0, sq_counts[k], 1);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    idle();
    check_out("squash2", 0, 0, 0, 1);
    for (int k = 0; k < PRF; k++) begin
      tick();
      if (k < PRF - 1) check_out($sformatf("squash2_scan%0d", k), 0, 0, sq_counts[k], 1);
      else             check_out("squash2_done", 1, 0, sq_counts[k], 0);
    end
    chk("invariant", int'(free_count_o) + 2, PRF);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sq_order%0d", i), int'(alloc_preg_o), sq_order[i]);
      drive(1, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    chk("sq_drained_ready", int'(alloc_ready_o), 0);
    chk("sq_drained_count", int'(free_count_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
